// File: rtl/fifo_read_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_read_ctrl_if
// Description : Bundles the FIFO read port (read_req / read_data / EMP) and
//               the downstream valid/ready stream of the read controller.
//               master = controller view, slave = FIFO + consumer view.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_read_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    // FIFO read port
    logic                  read_req;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  EMP;
    // Downstream stream
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_ready;

    modport master (
        output read_req,
        input  read_data,
        input  EMP,
        output m_valid,
        output m_data,
        input  m_ready
    );

    modport slave (
        input  read_req,
        output read_data,
        output EMP,
        input  m_valid,
        input  m_data,
        output m_ready
    );
endinterface
`default_nettype wire

// File: rtl/fifo_read_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_read_ctrl
// Description : Read-side FIFO controller. Issues read_req when the FIFO has
//               data and there is room for the word, absorbs the FIFO's
//               one-cycle read latency in a 2-entry circular buffer and
//               presents the words downstream as a valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_read_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    input  wire logic                 enable,
    fifo_read_ctrl_if.master          bus,
    output logic [CNT_WIDTH-1:0]      word_count,
    output logic                      busy
);

    localparam logic [1:0] c_OCC_EMPTY = 2'd0;
    localparam logic [2:0] c_DEPTH     = 3'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                  r_inflight;     // read_req was issued last cycle
    logic [1:0]            r_occ;          // buffered words, 0..2
    logic                  r_head;         // next word to present
    logic                  r_tail;         // next slot to fill
    logic [DATA_WIDTH-1:0] r_buf [2];
    logic [CNT_WIDTH-1:0]  r_word_count;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic                  w_valid;
    logic                  w_pop;
    logic [2:0]            w_level;        // occ + inflight - pop = next occ
    logic                  w_read_req;

    assign w_valid = (r_occ != c_OCC_EMPTY);
    assign w_pop   = w_valid && bus.m_ready;

    // pop implies occ >= 1, so the subtraction never underflows
    assign w_level = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};

    // A new read is allowed only if its word will find a free slot when it
    // lands next cycle; reset forces the strobe low regardless of inputs.
    assign w_read_req = !reset && enable && !bus.EMP && (w_level < c_DEPTH);

    assign bus.read_req = w_read_req;
    assign bus.m_valid  = w_valid;
    assign bus.m_data   = r_buf[r_head];
    assign word_count   = r_word_count;
    assign busy         = r_inflight || w_valid;

    // Remember whether a word is on its way from the FIFO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_read_req;
        end
    end

    // Capture the in-flight word at the tail slot and advance the tail
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_buf[0] <= '0;
            r_buf[1] <= '0;
            r_tail   <= 1'b0;
        end else if (r_inflight) begin
            r_buf[r_tail] <= bus.read_data;
            r_tail        <= ~r_tail;
        end
    end

    // Advance the head on every downstream transfer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head <= 1'b0;
        end else if (w_pop) begin
            r_head <= ~r_head;
        end
    end

    // Track occupancy: +1 on capture, -1 on pop, unchanged on both
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_occ <= c_OCC_EMPTY;
        end else begin
            r_occ <= w_level[1:0];
        end
    end

    // Count completed downstream transfers, wrapping naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_word_count <= '0;
        end else if (w_pop) begin
            r_word_count <= r_word_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: doc/fifo_read_ctrl.md
# fifo_read_ctrl

Read-side controller for the team's FIFO: drains words through the FIFO's `read_req` / `read_data` / `EMP` port and presents them downstream as a valid/ready stream. It is the consumer counterpart to the producer that drives `write_req` / `write_data` / `FULL`. A 2-entry output buffer absorbs the FIFO's one-cycle read latency, so the block sustains one word per cycle under no backpressure and never loses a word under backpressure. It sits between the FIFO instance and any downstream stream consumer on the same `clk`.

## Interface
- `DATA_WIDTH`, default 8: width of `read_data` and `m_data`.
- `CNT_WIDTH`, default 16: width of `word_count`.

Ports (direction, width, meaning):
- `clk`, in, 1: single clock; all logic on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `enable`, in, 1: permits new FIFO reads when high.
- `EMP`, in, 1: FIFO empty flag, valid each cycle.
- `read_req`, out, 1: FIFO read strobe; pops one word per cycle in which it is high.
- `read_data`, in, DATA_WIDTH: FIFO read data, valid exactly 1 cycle after `read_req` is sampled.
- `m_valid`, out, 1: downstream word available.
- `m_data`, out, DATA_WIDTH: downstream word.
- `m_ready`, in, 1: downstream accepts; transfer happens on `m_valid && m_ready` at the rising edge.
- `word_count`, out, CNT_WIDTH: number of completed downstream transfers, modulo 2^CNT_WIDTH.
- `busy`, out, 1: high while a read is in flight or the buffer is non-empty.

## Operation
- State:
  - `inflight` (1 bit): a `read_req` was issued last cycle.
  - `occ` (0..2): output buffer occupancy.
  - 2-entry circular buffer with head and tail pointers.
- `pop = m_valid && m_ready`.
- `read_req = enable && !EMP && (occ + inflight - pop) < 2`.
  - Combinational from `m_ready`, `EMP` and `enable`.
  - Never high while `EMP` is high.
- Capture: when `inflight` is 1, `read_data` is written at the tail. The tail wraps 1→0.
- Output: `m_valid = (occ != 0)` and `m_data = buffer[head]`. `m_data` is held stable while `m_valid && !m_ready`.
- On `pop`:
  - the head advances (wraps 1→0);
  - `word_count` increments, wrapping all-ones → 0.
- Simultaneous capture and pop: `occ` is unchanged, and both pointers advance.
- `enable` low: no new `read_req`. An in-flight word is still captured, and buffered words are still delivered.
- `busy = inflight || (occ != 0)`.
- Order: words leave in exactly the order they were read from the FIFO. No duplication and no drop.
- Invariant: `occ + inflight <= 2` at all times. Capture into a full buffer cannot occur; the bench asserts this.
- Mode summary:
  - IDLE: `occ == 0` and `!inflight`.
  - STREAM: a read is in flight or data is buffered, and `m_ready` is high.
  - STALL: `occ == 2` with `m_ready` low, so `read_req` is held low.

## Timing
- Reset values (asynchronous, while `reset` is high):
  - `m_valid` = 0, `m_data` = 0, `word_count` = 0, `busy` = 0;
  - `inflight` = 0, `occ` = 0, pointers = 0;
  - `read_req` = 0 regardless of its inputs.
- Reset mid-operation discards the buffer and any in-flight word. After reset is released, the first `read_req` can occur in the first cycle its condition holds.
- Latency:
  - `read_req` at edge N → word captured at edge N+1.
  - `m_valid` high from edge N+1.
  - Earliest downstream transfer at edge N+2.
- Throughput: 1 word/cycle while `!EMP`, `enable` and `m_ready` all hold.
- Backpressure: with `m_ready` low from an empty start, at most 2 reads are issued. `read_req` resumes in the same cycle that `m_ready` goes high.
- `EMP` rising in the cycle after a `read_req`: `read_req` drops immediately. The in-flight word is still delivered.

## Test plan
- Reset: hold `reset` high with arbitrary inputs → `read_req` = 0, `m_valid` = 0, `m_data` = 0, `word_count` = 0, `busy` = 0, including asynchronous assertion mid-cycle.
- Streaming: FIFO preloaded with 0x11, 0x22, 0x33, then `enable` = 1 and `m_ready` = 1 →
  - `read_req` high for 3 consecutive cycles;
  - `m_valid` high for 3 consecutive cycles starting 1 cycle after the first `read_req`;
  - `m_data` = 0x11, 0x22, 0x33;
  - `word_count` = 3 and `busy` = 0 afterwards.
- Backpressure: FIFO holds 0xA0..0xA4 and `m_ready` = 0 →
  - exactly 2 `read_req` pulses, then `read_req` stays low;
  - `m_data` held at 0xA0;
  - raise `m_ready` → 0xA0..0xA4 delivered in order, `word_count` = 5.
- Empty FIFO: `EMP` = 1 for 20 cycles with `enable` = 1 → `read_req` is never high, `m_valid` stays 0.
- Enable drop: drop `enable` right after a `read_req` while 4 words remain in the FIFO → no further `read_req`, the in-flight word is delivered, and `busy` falls after delivery.
- Reset mid-stream and wrap:
  - assert `reset` with `occ` = 2 → `m_valid` = 0 immediately, and no stale word appears after release;
  - separately, 65537 transfers → `word_count` = 1.
